// File: rtl/simple_lc3.sv
// simple_lc3: multi-cycle LC-3 subset core driving one word-addressed memory port.
// Every instruction starts with FETCH/FETCH_W/DECODE/EXEC; memory ops add wait-state pairs.
module simple_lc3 #(
    parameter logic [15:0] RESET_PC = 16'h3000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] addr,
    output logic [15:0] din,
    input  logic [15:0] dout,
    output logic        rd,
    input  logic        complete
);
    typedef enum logic [3:0] {
        FETCH, FETCH_W, DECODE, EXEC, IND, IND_W, READ, READ_W, STORE, STORE_W
    } state_t;
    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d;
    logic [2:0]  cc_q, cc_d;
    logic [15:0] r_q [8];
    logic        wr_en;
    logic [15:0] wr_val;
    logic [15:0] sr1, sr2, imm5, off6, off9, pc_off9, base_off6;
    assign sr1       = r_q[ir_q[8:6]];
    assign sr2       = r_q[ir_q[2:0]];
    assign imm5      = {{11{ir_q[4]}}, ir_q[4:0]};
    assign off6      = {{10{ir_q[5]}}, ir_q[5:0]};
    assign off9      = {{7{ir_q[8]}}, ir_q[8:0]};
    assign pc_off9   = pc_q + off9;
    assign base_off6 = sr1 + off6;
    assign rd   = state_q != STORE;
    assign din  = state_q == STORE ? r_q[ir_q[11:9]] : 16'h0;
    assign addr = state_q inside {IND, IND_W, READ, READ_W, STORE, STORE_W} ? mar_q : pc_q;
    // CC tracks whatever value is written to the register file this cycle
    assign cc_d = wr_en ? {wr_val[15], wr_val == 16'h0, !wr_val[15] && wr_val != 16'h0} : cc_q;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mar_d   = mar_q;
        wr_en   = 1'b0;
        wr_val  = 16'h0;
        case (state_q)
            FETCH:   state_d = FETCH_W;
            FETCH_W: if (complete) begin
                ir_d    = dout;
                pc_d    = pc_q + 16'd1;
                state_d = DECODE;
            end
            DECODE:  state_d = EXEC;
            EXEC: begin
                state_d = FETCH;
                case (ir_q[15:12])
                    4'b0001: begin wr_en = 1'b1; wr_val = sr1 + (ir_q[5] ? imm5 : sr2); end
                    4'b0101: begin wr_en = 1'b1; wr_val = sr1 & (ir_q[5] ? imm5 : sr2); end
                    4'b1001: begin wr_en = 1'b1; wr_val = ~sr1; end
                    4'b1110: begin wr_en = 1'b1; wr_val = pc_off9; end
                    4'b0000: if (|(ir_q[11:9] & cc_q)) pc_d = pc_off9;
                    4'b1100: pc_d = sr1;
                    4'b0010: begin mar_d = pc_off9;   state_d = READ;  end
                    4'b0110: begin mar_d = base_off6; state_d = READ;  end
                    4'b1010: begin mar_d = pc_off9;   state_d = IND;   end
                    4'b0011: begin mar_d = pc_off9;   state_d = STORE; end
                    4'b0111: begin mar_d = base_off6; state_d = STORE; end
                    4'b1011: begin mar_d = pc_off9;   state_d = IND;   end
                    default: state_d = FETCH;
                endcase
            end
            IND:     state_d = IND_W;
            IND_W:   if (complete) begin
                mar_d   = dout;
                state_d = ir_q[12] ? STORE : READ;
            end
            READ:    state_d = READ_W;
            READ_W:  if (complete) begin
                wr_en   = 1'b1;
                wr_val  = dout;
                state_d = FETCH;
            end
            STORE:   state_d = STORE_W;
            STORE_W: if (complete) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0;
            mar_q   <= 16'h0;
            cc_q    <= 3'b010;
            for (int i = 0; i < 8; i++) r_q[i] <= 16'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mar_q   <= mar_d;
            cc_q    <= cc_d;
            if (wr_en) r_q[ir_q[11:9]] <= wr_val;
        end
    end
endmodule

// File: tb/tb_simple_lc3.sv
// tb_simple_lc3: directed program run against a synchronous RAM model beside simple_lc3.
module tb_simple_lc3;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        complete = 1'b0;
    logic [15:0] addr, din, dout, rd_probe;
    logic        rd;
    logic [15:0] mem [65536];
    int          cyc = 0, wr_count = 0, checks = 0, errors = 0;
    logic [15:0] wr_addr = 16'h0;

    simple_lc3 dut (
        .clock(clock), .reset(reset), .addr(addr), .din(din),
        .dout(dout), .rd(rd), .complete(complete)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc++;
        if (rd === 1'b0) begin
            mem[addr] <= din;
            wr_count++;
            wr_addr = addr;
        end else begin
            dout <= mem[addr];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_fetch(input logic [15:0] a, output int at);
        bit found = 1'b0;
        at = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clock);
            if (dut.state_q == 4'd0 && addr == a) begin
                found = 1'b1;
                at = cyc;
            end
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL fetch_%h: observed=timeout expected=fetch", a);
        end
    endtask

    initial begin
        int t0, t1, snap;
        bit seen;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        mem[16'h3000] = 16'h5020; // AND R0,R0,#0
        mem[16'h3001] = 16'h102F; // ADD R0,R0,#15
        mem[16'h3002] = 16'h102F;
        mem[16'h3003] = 16'h1025; // ADD R0,R0,#5
        mem[16'h3004] = 16'h3004; // ST R0 -> 0x3009
        mem[16'h3005] = 16'h1221; // ADD R1,R0,#1
        mem[16'h3006] = 16'hE7F9; // LEA R3 -> 0x3000
        mem[16'h3007] = 16'h72CA; // STR R1,R3,#10
        mem[16'h3008] = 16'h0E04; // BRnzp -> 0x300D
        mem[16'h300D] = 16'hE5FE; // LEA R2 -> 0x300C
        mem[16'h300E] = 16'h35FC; // ST R2 -> 0x300B
        mem[16'h300F] = 16'hB3FB; // STI R1 via 0x300B
        mem[16'h3010] = 16'hA9FA; // LDI R4 via 0x300B
        mem[16'h3011] = 16'h9B3F; // NOT R5,R4
        mem[16'h3012] = 16'h0401; // BRz +1 (not taken)
        mem[16'h3013] = 16'h2C0C; // LD R6 <- 0x3020
        mem[16'h3014] = 16'h1DBF; // ADD R6,R6,#-1
        mem[16'h3015] = 16'h03FE; // BRp -2
        mem[16'h3016] = 16'h6ECA; // LDR R7,R3,#10
        mem[16'h3017] = 16'h3E09; // ST R7 -> 0x3021
        mem[16'h3018] = 16'hC0C0; // JMP R3
        mem[16'h3020] = 16'h0003;

        @(posedge clock); #1;
        chk("rst1_rd", {15'h0, rd}, 16'h1);
        chk("rst1_addr", addr, 16'h3000);
        chk("rst1_din", din, 16'h0);
        @(posedge clock); #1;
        chk("rst2_rd", {15'h0, rd}, 16'h1);
        chk("rst_pc", dut.pc_q, 16'h3000);
        chk("rst_ir", dut.ir_q, 16'h0);
        chk("rst_cc", {13'h0, dut.cc_q}, 16'h2);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("wait_addr", addr, 16'h3000);
            chk("wait_rd", {15'h0, rd}, 16'h1);
            chk("wait_ir", dut.ir_q, 16'h0);
        end
        complete = 1'b1;

        wait_fetch(16'h3001, t0);
        chk("first_ir", dut.ir_q, 16'h5020);
        wait_fetch(16'h3002, t1);
        chk("lat_alu", 16'(t1 - t0), 16'd4);
        wait_fetch(16'h3004, t0);
        wait_fetch(16'h3005, t1);
        chk("lat_st", 16'(t1 - t0), 16'd6);
        chk("st_mem", mem[16'h3009], 16'h0023);
        chk("st_cc", {13'h0, dut.cc_q}, 16'h1);
        chk("st_wcount", 16'(wr_count), 16'd1);
        chk("st_waddr", wr_addr, 16'h3009);

        wait_fetch(16'h3008, t0);
        chk("str_mem", mem[16'h300A], 16'h0024);
        chk("str_wcount", 16'(wr_count), 16'd2);

        wait_fetch(16'h300F, t0);
        wait_fetch(16'h3010, t1);
        chk("lat_sti", 16'(t1 - t0), 16'd8);
        chk("ptr_mem", mem[16'h300B], 16'h300C);
        chk("sti_mem", mem[16'h300C], 16'h0024);
        wait_fetch(16'h3011, t0);
        chk("lat_ldi", 16'(t0 - t1), 16'd8);
        chk("ldi_r4", dut.r_q[4], 16'h0024);
        chk("ldi_cc", {13'h0, dut.cc_q}, 16'h1);
        wait_fetch(16'h3012, t0);
        chk("not_r5", dut.r_q[5], 16'hFFDB);
        chk("not_cc", {13'h0, dut.cc_q}, 16'h4);
        wait_fetch(16'h3013, t1);
        chk("lat_brz", 16'(t1 - t0), 16'd4);

        wait_fetch(16'h3016, t0);
        chk("loop_r6", dut.r_q[6], 16'h0);
        chk("loop_cc", {13'h0, dut.cc_q}, 16'h2);
        wait_fetch(16'h3017, t1);
        chk("lat_ldr", 16'(t1 - t0), 16'd6);
        wait_fetch(16'h3018, t0);
        chk("ldr_mem", mem[16'h3021], 16'h0024);
        chk("all_wcount", 16'(wr_count), 16'd5);
        wait_fetch(16'h3000, t1);
        chk("lat_jmp", 16'(t1 - t0), 16'd4);
        chk("jmp_pc", dut.pc_q, 16'h3000);

        wait_fetch(16'h3004, t0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (rd === 1'b0) seen = 1'b1;
        end
        chk("store_seen", {15'h0, seen}, 16'h1);
        chk("store_addr", addr, 16'h3009);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("mid_rd", {15'h0, rd}, 16'h1);
        chk("mid_pc", dut.pc_q, 16'h3000);
        chk("mid_addr", addr, 16'h3000);
        chk("mid_cc", {13'h0, dut.cc_q}, 16'h2);
        for (int i = 0; i < 8; i++) chk($sformatf("mid_r%0d", i), dut.r_q[i], 16'h0);
        snap = wr_count;
        repeat (6) @(posedge clock);
        #1;
        chk("mid_nowrite", 16'(wr_count - snap), 16'd0);
        chk("mid_mem", mem[16'h3009], 16'h0023);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
